johnson_counter_param: RTL and testbench

//  Parametrised twisted-ring (Johnson) counter with a 2*WIDTH-state cycle.

---
 rtl/johnson_pkg.sv | 62 ++++++
 rtl/johnson_counter_param_decode.sv | 25 ++
 rtl/johnson_counter_param.sv | 93 +++++++++
 tb/tb_johnson_counter_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
`default_nettype none
// =============================================================================
// Module  : johnson_pkg
// Brief   : Johnson ring helpers: phase<->ring mapping and legality check.
// Revision: 1.0
// =============================================================================
package johnson_pkg;

    // Helpers work on a fixed-width vector so any ring width up to this fits.
    localparam int MAX_W = 32;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic logic [MAX_W-1:0] phase_to_ring(input int k, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if (k < w) r[i] = (i < k);
                else       r[i] = (i >= k - w);
            end
        end
        return r;
    endfunction

    function automatic int ring_to_phase(input logic [MAX_W-1:0] q, input int w);
        int ones;
        ones = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w && q[i]) ones++;
        end
        return q[w-1] ? (2 * w - ones) : ones;
    endfunction

    function automatic logic ring_is_legal(input logic [MAX_W-1:0] q, input int w);
        int   ones;
        logic lsb_ok;
        logic msb_ok;
        ones   = 0;
        lsb_ok = 1'b1;
        msb_ok = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w && q[i]) ones++;
        end
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                if (q[i] != (i < ones))      lsb_ok = 1'b0;
                if (q[i] != (i >= w - ones)) msb_ok = 1'b0;
            end
        end
        return lsb_ok | msb_ok;
    endfunction

    function automatic logic phase_in_range(input int k, input int w);
        return (k >= 0) && (k < 2 * w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_counter_param_decode.sv
`default_nettype none
// =============================================================================
// Module  : johnson_decode
// Brief   : Combinational ring decode: binary phase index and legality flag.
// Revision: 1.0
// =============================================================================
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic [IDXW-1:0]  idx,
    output logic             legal
);

    logic [MAX_W-1:0] w_q_ext;

    assign w_q_ext = MAX_W'(q);
    assign idx     = IDXW'(ring_to_phase(w_q_ext, WIDTH));
    assign legal   = ring_is_legal(w_q_ext, WIDTH);

endmodule
`default_nettype wire

// File: rtl/johnson_counter_param.sv
`default_nettype none
// =============================================================================
// Module  : johnson_counter_param
// Brief   : Up/down Johnson counter with phase load, wrap pulse, error recovery.
// Revision: 1.0
// =============================================================================
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [IDXW-1:0]  load_idx,
    output logic [WIDTH-1:0] q,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_ring_zero = '0;
    localparam logic [WIDTH-1:0] c_ring_last = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_up;
    logic [WIDTH-1:0] w_q_dn;
    logic [WIDTH-1:0] w_load_ring;
    logic             w_load_ok;
    logic             w_legal;
    logic             w_wrap_next;
    logic             w_err_next;
    dir_e             w_dir;

    johnson_decode #(.WIDTH(WIDTH)) u_decode (
        .q     (r_q),
        .idx   (idx),
        .legal (w_legal)
    );

    assign w_dir       = dir_e'(dir);
    assign w_q_up      = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
    assign w_q_dn      = {~r_q[0], r_q[WIDTH-1:1]};
    assign w_load_ok   = phase_in_range(int'(load_idx), WIDTH);
    assign w_load_ring = WIDTH'(phase_to_ring(int'(load_idx), WIDTH));

    // Load beats correction beats stepping; wrap only ever comes from a step.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        w_err_next  = 1'b0;
        if (load) begin
            if (w_load_ok) w_q_next   = w_load_ring;
            else           w_err_next = 1'b1;
        end else if (!w_legal) begin
            w_q_next   = '0;
            w_err_next = 1'b1;
        end else if (en) begin
            if (w_dir == DIR_UP) begin
                w_q_next    = w_q_up;
                w_wrap_next = (r_q == c_ring_last);
            end else begin
                w_q_next    = w_q_dn;
                w_wrap_next = (r_q == c_ring_zero);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
            r_err  <= w_err_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_johnson_counter_param.sv
`default_nettype none
// =============================================================================
// Module  : tb_johnson_counter_param
// Brief   : Vector-table bench for WIDTH=4 and WIDTH=5 Johnson counters.
// Revision: 1.0
// =============================================================================
module tb_johnson_counter_param;

    typedef struct {
        bit sel5;
        bit load;
        int lidx;
        bit en;
        bit dir;
        int q;
        int idx;
        bit wrap;
        bit err;
        bit chk_idx;
        int tag;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en4, dir4, load4;
    logic [2:0] lidx4;
    logic [3:0] q4;
    logic [2:0] idx4;
    logic       wrap4, err4;
    logic       en5, dir5, load5;
    logic [3:0] lidx5;
    logic [4:0] q5;
    logic [3:0] idx5;
    logic       wrap5, err5;

    int   vectors     = 0;
    int   miscompares = 0;
    int   next_tag    = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    johnson_counter_param #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .en(en4), .dir(dir4), .load(load4),
        .load_idx(lidx4), .q(q4), .idx(idx4), .wrap(wrap4), .err(err4)
    );

    johnson_counter_param #(.WIDTH(5)) u5 (
        .clk(clk), .reset(reset), .en(en5), .dir(dir5), .load(load5),
        .load_idx(lidx5), .q(q5), .idx(idx5), .wrap(wrap5), .err(err5)
    );

    function automatic vec_t mk(bit sel5, bit load, int lidx, bit en, bit dir,
                                int q, int idx, bit wrap, bit err, bit chk_idx = 1'b1);
        vec_t v;
        v.sel5 = sel5; v.load = load; v.lidx = lidx; v.en = en; v.dir = dir;
        v.q = q; v.idx = idx; v.wrap = wrap; v.err = err; v.chk_idx = chk_idx;
        v.tag = 0;
        return v;
    endfunction

    // Reference phase->ring mapping for the 5-bit ring, straight from the closed form.
    function automatic int ring5(int k);
        if (k < 5) return (1 << k) - 1;
        return (~((1 << (k - 5)) - 1)) & 'h1f;
    endfunction

    task automatic check(input string what, input int tag,
                         input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec#%0d: got %0h expected %0h", what, tag, act, exp);
        end
    endtask

    task automatic score();
        vec_t        e;
        logic [31:0] aq, ai, aw, ae;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        e = sb.pop_front();
        if (e.sel5) begin
            aq = 32'(q5); ai = 32'(idx5); aw = 32'(wrap5); ae = 32'(err5);
        end else begin
            aq = 32'(q4); ai = 32'(idx4); aw = 32'(wrap4); ae = 32'(err4);
        end
        check("q", e.tag, aq, e.q);
        if (e.chk_idx) check("idx", e.tag, ai, e.idx);
        check("wrap", e.tag, aw, 32'(e.wrap));
        check("err", e.tag, ae, 32'(e.err));
    endtask

    // Called at a negedge: drive, queue expectation, sample 1 ns after posedge.
    task automatic apply(input vec_t v);
        if (v.sel5) begin
            en5 = v.en; dir5 = v.dir; load5 = v.load; lidx5 = 4'(v.lidx);
            en4 = 1'b0; load4 = 1'b0;
        end else begin
            en4 = v.en; dir4 = v.dir; load4 = v.load; lidx4 = 3'(v.lidx);
            en5 = 1'b0; load5 = 1'b0;
        end
        v.tag = next_tag++;
        sb.push_back(v);
        @(posedge clk);
        #1;
        score();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        en4 = 0; dir4 = 0; load4 = 0; lidx4 = '0;
        en5 = 0; dir5 = 0; load5 = 0; lidx5 = '0;

        tbl.push_back(mk(0,0,0,1,1, 'b0001,1,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b0011,2,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b0111,3,0,0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,1, 'b0111,3,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b1111,4,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b1110,5,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b1100,6,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b1000,7,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b0000,0,1,0));
        tbl.push_back(mk(0,0,0,1,0, 'b1000,7,1,0));
        tbl.push_back(mk(0,0,0,1,0, 'b1100,6,0,0));
        tbl.push_back(mk(0,1,5,1,1, 'b1110,5,0,0));
        tbl.push_back(mk(0,1,0,1,0, 'b0000,0,0,0));
        tbl.push_back(mk(0,0,0,1,0, 'b1000,7,1,0));
        tbl.push_back(mk(0,1,7,0,0, 'b1000,7,0,0));
        tbl.push_back(mk(0,0,0,1,1, 'b0000,0,1,0));
        tbl.push_back(mk(0,1,3,0,0, 'b0111,3,0,0));

        #1;
        check("reset_q4",    -1, 32'(q4),    0);
        check("reset_idx4",  -1, 32'(idx4),  0);
        check("reset_wrap4", -1, 32'(wrap4), 0);
        check("reset_err4",  -1, 32'(err4),  0);
        check("reset_q5",    -1, 32'(q5),    0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Asynchronous reset mid-count at 0111, checked before the next edge.
        #2;
        reset = 1'b1;
        #1;
        check("midreset_q",    -2, 32'(q4),    0);
        check("midreset_idx",  -2, 32'(idx4),  0);
        check("midreset_wrap", -2, 32'(wrap4), 0);
        check("midreset_err",  -2, 32'(err4),  0);
        @(negedge clk);
        reset = 1'b0;

        // Illegal ring patterns are cleared with an err pulse, enable or not.
        force u4.r_q = 4'b0101;
        #1;
        release u4.r_q;
        apply(mk(0,0,0,0,0, 'b0000,0,0,1));
        apply(mk(0,0,0,0,0, 'b0000,0,0,0));
        force u4.r_q = 4'b0110;
        #1;
        release u4.r_q;
        apply(mk(0,0,0,1,1, 'b0000,0,0,1));
        apply(mk(0,0,0,1,1, 'b0001,1,0,0));

        // WIDTH=5: two full 10-phase up cycles.
        for (int k = 1; k <= 20; k++)
            apply(mk(1,0,0,1,1, ring5(k % 10), k % 10, (k % 10) == 0, 0));

        // WIDTH=5: out-of-range load holds q and pulses err.
        apply(mk(1,1,3,0,0,  ring5(3), 3, 0, 0));
        apply(mk(1,1,12,1,1, ring5(3), 3, 0, 1));
        apply(mk(1,0,0,0,0,  ring5(3), 3, 0, 0));
        apply(mk(1,1,10,0,0, ring5(3), 3, 0, 1));
        apply(mk(1,1,9,0,0,  ring5(9), 9, 0, 0));
        apply(mk(1,0,0,1,0,  ring5(8), 8, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
